// File: rtl/demux_burst_sched_pkg.sv
// Shared encodings for the demux burst scheduler: FSM states and mode values.
package demux_burst_sched_pkg;

  typedef logic [0:0] dmx_state_t;

  localparam dmx_state_t DMX_IDLE  = 1'b0;
  localparam dmx_state_t DMX_BURST = 1'b1;

  localparam logic DMX_MODE_RR  = 1'b0;
  localparam logic DMX_MODE_FIX = 1'b1;

endpackage

// File: rtl/demux_burst_sched_out_stage.sv
// One-entry registered output stage: holds a word and its channel tag,
// decodes the one-hot per-channel valid and produces the upstream ready.
module demux_out_stage #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic [SEL_W-1:0]   cap_sel,
  input  logic [DATA_W-1:0]  cap_data,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               in_ready,
  output logic               hold_v
);

  logic [SEL_W-1:0]  hold_sel;
  logic [DATA_W-1:0] hold_data;
  logic              drain;

  // Only the channel the held word is tagged for sees a valid.
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_valid[i] = hold_v && (hold_sel == SEL_W'(i));
    end
  end

  // Since out_valid is one-hot, this is out_ready of the held channel.
  assign drain    = |(out_valid & out_ready);
  assign in_ready = !hold_v || drain;
  assign out_data = hold_data;

  // A new word replaces the held one (also when it drains this cycle); a drain alone empties the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_sel  <= '0;
      hold_data <= '0;
    end else if (capture) begin
      hold_v    <= 1'b1;
      hold_sel  <= cap_sel;
      hold_data <= cap_data;
    end else if (drain) begin
      hold_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_burst_sched.sv
// Burst scheduler for a 1-to-N demux: picks the destination channel of each
// accepted word, round-robin in bursts of BURST words or pinned to fix_sel.
module demux_burst_sched
  import demux_burst_sched_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1,
  parameter int BURST   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               mode,
  input  logic [SEL_W-1:0]   fix_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  localparam int               CNT_W    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OUT - 1);

  dmx_state_t       state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_sel;
  logic             lock_rr;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] fsel;
  logic [SEL_W-1:0] cur;
  logic             accept;
  logic             hold_v;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] p);
    return (p == SEL_LAST) ? '0 : p + SEL_W'(1);
  endfunction

  // Out-of-range fixed channels fall back to channel 0.
  assign fsel = (int'(fix_sel) >= NUM_OUT) ? '0 : fix_sel;

  // An open burst stays on its locked channel regardless of mode/fix_sel.
  always_comb begin
    if (state == DMX_BURST) begin
      cur = lock_sel;
    end else if (mode == DMX_MODE_FIX) begin
      cur = fsel;
    end else begin
      cur = rr_ptr;
    end
  end

  assign accept = in_valid && in_ready;
  assign sel    = cur;
  assign busy   = (state == DMX_BURST) || hold_v;

  // Burst FSM: opens a burst on the first accepted word, counts words, and
  // advances the round-robin pointer only when an RR-opened burst closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DMX_IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      lock_sel <= '0;
      lock_rr  <= 1'b0;
    end else if (accept) begin
      if (state == DMX_IDLE) begin
        if (BURST == 1) begin
          if (mode == DMX_MODE_RR) begin
            rr_ptr <= wrap_inc(cur);
          end
        end else begin
          state    <= DMX_BURST;
          lock_sel <= cur;
          lock_rr  <= (mode == DMX_MODE_RR);
          cnt      <= CNT_W'(1);
        end
      end else if (cnt == CNT_LAST) begin
        state <= DMX_IDLE;
        cnt   <= '0;
        if (lock_rr) begin
          rr_ptr <= wrap_inc(lock_sel);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  demux_out_stage #(
    .DATA_W  (DATA_W),
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .capture   (accept),
    .cap_sel   (cur),
    .cap_data  (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .in_ready  (in_ready),
    .hold_v    (hold_v)
  );

endmodule

// File: tb/tb_demux_burst_sched.sv
// Testbench for demux_burst_sched: directed scenarios plus randomized traffic
// checked against a transaction-level model of bursts and the holding slot.
module tb_demux_burst_sched;

  localparam int DW = 8;
  localparam int NA = 2;
  localparam int SA = 1;
  localparam int BA = 4;
  localparam int NB = 5;
  localparam int SB = 3;
  localparam int BB = 1;
  localparam int VW = NA + DW + SA + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-channel, 4-word-burst instance
  logic          rst, in_valid, in_ready, mode, busy;
  logic [DW-1:0] in_data, out_data;
  logic [SA-1:0] fix_sel, sel;
  logic [NA-1:0] out_valid, out_ready;

  // 5-channel, single-word-burst instance
  logic          b_rst, b_in_valid, b_in_ready, b_mode, b_busy;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [SB-1:0] b_fix_sel, b_sel;
  logic [NB-1:0] b_out_valid, b_out_ready;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: holding slot plus burst bookkeeping as plain integers
  bit m_hold_v;
  int m_hold_ch, m_hold_data;
  int m_left;
  int m_lock;
  bit m_lock_rr;
  int m_rr;

  int rec_ch[$];
  int rec_data[$];

  logic [VW-1:0] exp_v, obs_v;

  demux_burst_sched #(.DATA_W(DW), .NUM_OUT(NA), .SEL_W(SA), .BURST(BA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .fix_sel(fix_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel(sel), .busy(busy)
  );

  demux_burst_sched #(.DATA_W(DW), .NUM_OUT(NB), .SEL_W(SB), .BURST(BB)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .mode(b_mode), .fix_sel(b_fix_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .sel(b_sel), .busy(b_busy)
  );

  function automatic void model_reset();
    m_hold_v = 1'b0; m_hold_ch = 0; m_hold_data = 0;
    m_left = 0; m_lock = 0; m_lock_rr = 1'b0; m_rr = 0;
  endfunction

  function automatic int model_chan();
    if (m_left > 0) return m_lock;
    if (mode) return (int'(fix_sel) < NA) ? int'(fix_sel) : 0;
    return m_rr;
  endfunction

  function automatic bit model_ready();
    return !m_hold_v || out_ready[m_hold_ch];
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [NA-1:0] v;
    v = '0;
    if (m_hold_v) v[m_hold_ch] = 1'b1;
    return {v, DW'(m_hold_data), model_ready(), SA'(model_chan()), (m_left > 0) || m_hold_v};
  endfunction

  function automatic void model_clock();
    bit acc, drn;
    int ch;
    if (rst) begin
      model_reset();
      return;
    end
    acc = in_valid && model_ready();
    drn = m_hold_v && out_ready[m_hold_ch];
    if (acc) begin
      ch = model_chan();
      if (m_left == 0) begin
        if (BA == 1) begin
          if (!mode) m_rr = (ch + 1) % NA;
        end else begin
          m_left = BA - 1; m_lock = ch; m_lock_rr = !mode;
        end
      end else begin
        m_left--;
        if (m_left == 0 && m_lock_rr) m_rr = (m_lock + 1) % NA;
      end
      m_hold_v = 1'b1; m_hold_ch = ch; m_hold_data = int'(in_data);
    end else if (drn) begin
      m_hold_v = 1'b0;
    end
  endfunction

  function automatic int hs_chan();
    for (int i = 0; i < NA; i++) if (out_valid[i] && out_ready[i]) return i;
    return -1;
  endfunction

  // Log this cycle's output handshake, advance the model, move to next cycle
  task automatic step_a();
    int h;
    h = hs_chan();
    if (!rst && h >= 0) begin
      rec_ch.push_back(h);
      rec_data.push_back(int'(out_data));
    end
    model_clock();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset_a();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    rec_ch.delete(); rec_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; mode = 1'b0; fix_sel = '0; out_ready = '1;
    b_rst = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h55; b_mode = 1'b0; b_fix_sel = '0; b_out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; b_rst = 1'b0; b_in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 00", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (sel !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sel: got %b expected 0", sel); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (out_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
    tests_run++;
    if (b_out_valid !== 5'b00000 || b_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_b: got valid=%b busy=%b expected 00000/0", b_out_valid, b_busy);
    end
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_rr_stream();
    logic [NA-1:0] want_ov;
    for (int c = 0; c < 10; c++) begin
      mode = 1'b0; out_ready = 2'b11;
      in_valid = (c < 8); in_data = DW'(c + 1);
      #1;
      exp_v = model_vec(); obs_v = {out_valid, out_data, in_ready, sel, busy};
      tests_run++;
      if (obs_v !== exp_v) begin tests_failed++; $display("[TB] FAIL rr_stream_c%0d: got %h expected %h", c, obs_v, exp_v); end
      want_ov = (c == 0 || c == 9) ? 2'b00 : (c <= 4 ? 2'b01 : 2'b10);
      tests_run++;
      if (out_valid !== want_ov || (c >= 1 && c <= 8 && out_data !== DW'(c))) begin
        tests_failed++;
        $display("[TB] FAIL rr_word_c%0d: got valid=%b data=%0d expected valid=%b data=%0d", c, out_valid, out_data, want_ov, c);
      end
      step_a();
    end
  endtask

  task automatic test_backpressure();
    int next;
    next = 1;
    rec_ch.delete(); rec_data.delete();
    for (int c = 0; c < 12; c++) begin
      mode = 1'b0;
      out_ready = (c == 0) ? 2'b11 : ((c < 4) ? 2'b00 : 2'b01);
      in_valid = (next <= 4); in_data = DW'(next);
      #1;
      exp_v = model_vec(); obs_v = {out_valid, out_data, in_ready, sel, busy};
      tests_run++;
      if (obs_v !== exp_v) begin tests_failed++; $display("[TB] FAIL backpressure_c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (c >= 1 && c <= 3) begin
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== 8'd1) begin
          tests_failed++; $display("[TB] FAIL stall_c%0d: got in_ready=%b data=%0d expected 0/1", c, in_ready, out_data);
        end
      end
      if (in_valid && model_ready()) next++;
      step_a();
    end
    tests_run++;
    if (rec_ch.size() != 4) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d expected 4", rec_ch.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= rec_ch.size() || rec_ch[i] != 0 || rec_data[i] != i + 1) begin
        tests_failed++; $display("[TB] FAIL bp_word%0d: got ch/data %0d/%0d expected 0/%0d", i,
          (i < rec_ch.size()) ? rec_ch[i] : -1, (i < rec_data.size()) ? rec_data[i] : -1, i + 1);
      end
    end
  endtask

  task automatic test_mode_change();
    int want_ch[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    pulse_reset_a();
    for (int c = 0; c < 13; c++) begin
      out_ready = 2'b11; fix_sel = 1'b1;
      mode = (c >= 2 && c < 8);
      in_valid = (c < 8) || (c == 10);
      in_data = (c < 8) ? DW'(c + 1) : 8'd9;
      #1;
      exp_v = model_vec(); obs_v = {out_valid, out_data, in_ready, sel, busy};
      tests_run++;
      if (obs_v !== exp_v) begin tests_failed++; $display("[TB] FAIL mode_change_c%0d: got %h expected %h", c, obs_v, exp_v); end
      step_a();
    end
    tests_run++;
    if (rec_ch.size() != 9) begin tests_failed++; $display("[TB] FAIL mc_count: got %0d expected 9", rec_ch.size()); end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (i >= rec_ch.size() || rec_ch[i] != want_ch[i] || rec_data[i] != i + 1) begin
        tests_failed++; $display("[TB] FAIL mc_word%0d: got ch/data %0d/%0d expected %0d/%0d", i,
          (i < rec_ch.size()) ? rec_ch[i] : -1, (i < rec_data.size()) ? rec_data[i] : -1, want_ch[i], i + 1);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int want_ch[6]   = '{0, 0, 0, 0, 0, 1};
    int want_data[6] = '{1, 3, 4, 5, 6, 7};
    pulse_reset_a();
    for (int c = 0; c < 12; c++) begin
      mode = 1'b0; fix_sel = '0;
      rst = (c == 3);
      out_ready = (c == 2) ? 2'b00 : 2'b11;
      in_valid = (c < 2) || (c == 3) || (c >= 5 && c < 10);
      in_data = (c < 2) ? DW'(c + 1) : ((c == 3) ? 8'h55 : DW'(c - 2));
      #1;
      exp_v = model_vec(); obs_v = {out_valid, out_data, in_ready, sel, busy};
      tests_run++;
      if (obs_v !== exp_v) begin tests_failed++; $display("[TB] FAIL reset_mid_c%0d: got %h expected %h", c, obs_v, exp_v); end
      if (c == 4) begin
        tests_run++;
        if (out_valid !== 2'b00 || busy !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL post_reset: got valid=%b busy=%b expected 00/0", out_valid, busy);
        end
      end
      step_a();
    end
    rst = 1'b0;
    tests_run++;
    if (rec_ch.size() != 6) begin tests_failed++; $display("[TB] FAIL rmb_count: got %0d expected 6", rec_ch.size()); end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i >= rec_ch.size() || rec_ch[i] != want_ch[i] || rec_data[i] != want_data[i]) begin
        tests_failed++; $display("[TB] FAIL rmb_word%0d: got ch/data %0d/%0d expected %0d/%0d", i,
          (i < rec_ch.size()) ? rec_ch[i] : -1, (i < rec_data.size()) ? rec_data[i] : -1, want_ch[i], want_data[i]);
      end
    end
  endtask

  task automatic test_burst1_wrap();
    int fix_in[4]  = '{5, 3, 7, 4};
    int fix_exp[4] = '{0, 3, 0, 4};
    for (int c = 0; c < 8; c++) begin
      b_mode = 1'b0; b_out_ready = '1;
      b_in_valid = (c < 6); b_in_data = DW'(c + 1);
      #1;
      if (c < 6) begin
        tests_run++;
        if (b_sel !== SB'(c % NB)) begin tests_failed++; $display("[TB] FAIL wrap_sel_c%0d: got %0d expected %0d", c, b_sel, c % NB); end
      end
      if (c >= 1 && c <= 6) begin
        tests_run++;
        if (b_out_valid !== NB'(1 << ((c - 1) % NB)) || b_out_data !== DW'(c)) begin
          tests_failed++; $display("[TB] FAIL wrap_out_c%0d: got valid=%b data=%0d expected ch%0d data=%0d",
            c, b_out_valid, b_out_data, (c - 1) % NB, c);
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      b_mode = 1'b1; b_fix_sel = SB'(fix_in[k]); b_in_valid = 1'b1; b_in_data = DW'(8'h40 + k);
      #1;
      tests_run++;
      if (b_sel !== SB'(fix_exp[k])) begin tests_failed++; $display("[TB] FAIL fix_sel%0d: got %0d expected %0d", fix_in[k], b_sel, fix_exp[k]); end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      #1;
      tests_run++;
      if (b_out_valid !== NB'(1 << fix_exp[k]) || b_out_data !== DW'(8'h40 + k)) begin
        tests_failed++; $display("[TB] FAIL fix_out%0d: got valid=%b data=%h expected ch%0d data=%h",
          fix_in[k], b_out_valid, b_out_data, fix_exp[k], 8'h40 + k);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    pulse_reset_a();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = DW'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 1'($urandom);
      fix_sel = SA'($urandom);
      out_ready = NA'($urandom);
      #1;
      exp_v = model_vec(); obs_v = {out_valid, out_data, in_ready, sel, busy};
      tests_run++;
      if (obs_v !== exp_v) begin tests_failed++; $display("[TB] FAIL random_c%0d: got %h expected %h", c, obs_v, exp_v); end
      step_a();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rr_stream();
    test_backpressure();
    test_mode_change();
    test_reset_mid_burst();
    test_burst1_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
